// File: rtl/mem_bus_pkg.sv
// ============================================================================
//  Module      : mem_bus_pkg
//  Description : Shared types and constants for the memory bus controller.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_bus_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        STROBE  = 3'd2,
        RELEASE = 3'd3,
        DONE    = 3'd4
    } state_t;

    localparam logic MEM_READ  = 1'b1;
    localparam logic MEM_WRITE = 1'b0;

    localparam int DEFAULT_ADDR_W = 16;
    localparam int DEFAULT_DATA_W = 16;

endpackage

`default_nettype wire

// File: rtl/sync_2ff.sv
// ============================================================================
//  Module      : sync_2ff
//  Description : Two-flop synchroniser for a single asynchronous level.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic r_meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_meta <= 1'b0;
            q      <= 1'b0;
        end else begin
            r_meta <= d;
            q      <= r_meta;
        end
    end

endmodule

`default_nettype wire

// File: rtl/mem_bus_ctrl.sv
// ============================================================================
//  Module      : mem_bus_ctrl
//  Description : CPU-side bus master for an asynchronous EN/RW/MFC memory.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_bus_ctrl
    import mem_bus_pkg::*;
#(
    parameter int ADDR_W  = DEFAULT_ADDR_W,
    parameter int DATA_W  = DEFAULT_DATA_W,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_datain,
    output logic              mem_rw,
    output logic              mem_en,
    input  logic [DATA_W-1:0] mem_dataout,
    input  logic              mem_mfc
);

    localparam int                CNT_W   = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(TIMEOUT - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_err_pending;
    logic             w_mfc_s;

    sync_2ff u_mfc_sync (
        .clk   (clk),
        .reset (reset),
        .d     (mem_mfc),
        .q     (w_mfc_s)
    );

    // All outputs are registered; each state sets up the values seen in the next one.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_err_pending <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
            rdata         <= '0;
            mem_addr      <= '0;
            mem_datain    <= '0;
            mem_rw        <= MEM_READ;
            mem_en        <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req) begin
                        mem_addr   <= cpu_addr;
                        mem_datain <= cpu_wdata;
                        mem_rw     <= we ? MEM_WRITE : MEM_READ;
                        busy       <= 1'b1;
                        r_cnt      <= '0;
                        r_state    <= SETUP;
                    end
                end

                SETUP: begin
                    mem_en  <= 1'b1;
                    r_cnt   <= '0;
                    r_state <= STROBE;
                end

                STROBE: begin
                    if (w_mfc_s) begin
                        if (mem_rw == MEM_READ) begin
                            rdata <= mem_dataout;
                        end
                        mem_en  <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= RELEASE;
                    end else if (r_cnt == CNT_MAX) begin
                        r_err_pending <= 1'b1;
                        mem_en        <= 1'b0;
                        r_cnt         <= '0;
                        r_state       <= RELEASE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                RELEASE: begin
                    // Memory drops MFC only after it sees EN fall; wait for that here.
                    if (!w_mfc_s) begin
                        done    <= 1'b1;
                        err     <= r_err_pending;
                        r_state <= DONE;
                    end else if (r_cnt == CNT_MAX) begin
                        r_err_pending <= 1'b1;
                        done          <= 1'b1;
                        err           <= 1'b1;
                        r_state       <= DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                DONE: begin
                    done          <= 1'b0;
                    err           <= 1'b0;
                    busy          <= 1'b0;
                    r_err_pending <= 1'b0;
                    r_cnt         <= '0;
                    r_state       <= IDLE;
                end

                default: begin
                    mem_en  <= 1'b0;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    err     <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
